// File: rtl/uart_rx_8x.sv
// rtl/uart_rx_8x.sv - 8x oversampling UART receiver, optional even parity via UART_RX_PARITY_EN
`timescale 1ns/1ps
module uart_rx_8x #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_tick,
   input  logic       rxd,
   input  logic       rd,
   output logic [7:0] data,
   output logic       data_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t                 state_q, state_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [7:0]             shift_q, shift_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [7:0]             data_q, data_d;
   logic                   data_ready_q, data_ready_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   rxs;
   logic                   complete;
   logic                   stop_bad;
`ifdef UART_RX_PARITY_EN
   logic                   par_q, par_d;
   logic                   parity_err_q, parity_err_d;
`endif

   assign rxs = sync_q[SYNC_STAGES-1];

   // Next-state logic: everything except the synchronizer only moves on rx_tick
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      complete = 1'b0;
      stop_bad = 1'b0;
      sync_d   = {sync_q[SYNC_STAGES-2:0], rxd};
`ifdef UART_RX_PARITY_EN
      par_d    = par_q;
`endif
      if (rx_tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rxs) begin
                  state_d = S_START;
                  cnt_d   = 3'd0;
               end
            end
            S_START: begin
               // Mid-start-bit check rejects short low glitches
               if (cnt_q == 3'd3) begin
                  if (rxs) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     cnt_d   = 3'd0;
                     idx_d   = 3'd0;
                  end
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            S_DATA: begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  shift_d = {rxs, shift_q[7:1]};
                  idx_d   = idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  par_d   = rxs;
                  state_d = S_STOP;
               end
            end
`endif
            S_STOP: begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  complete = 1'b1;
                  if (rxs) begin
                     state_d = S_IDLE;
                  end else begin
                     stop_bad = 1'b1;
                     state_d  = S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               // Line must return high before a new start edge is accepted
               if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output register inputs: load on completion, rd clears the ready flag
   always_comb begin
      data_d       = complete ? shift_q : data_q;
      data_ready_d = complete ? 1'b1 : (rd ? 1'b0 : data_ready_q);
      overrun_d    = complete & data_ready_q & ~rd;
      frame_err_d  = stop_bad;
`ifdef UART_RX_PARITY_EN
      parity_err_d = complete & ((^shift_q) ^ par_q);
`endif
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 3'd0;
         idx_q        <= 3'd0;
         shift_q      <= 8'h00;
         sync_q       <= '1;
         data_q       <= 8'h00;
         data_ready_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         sync_q       <= sync_d;
         data_q       <= data_d;
         data_ready_q <= data_ready_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign data       = data_q;
   assign data_ready = data_ready_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_8x.sv
// tb/tb_uart_rx_8x.sv - scoreboard bench for uart_rx_8x (UART_RX_PARITY_EN aware)
`timescale 1ns/1ps
module tb_uart_rx_8x;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       ov;
      logic       pe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_tick = 1'b0;
   logic       rxd = 1'b1;
   logic       rd = 1'b0;
   logic [7:0] data;
   logic       data_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;
   logic       parity_err;

   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;
   bit         unread = 1'b0;

   uart_rx_8x #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_tick    (rx_tick),
      .rxd        (rxd),
      .rd         (rd),
      .data       (data),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   initial forever #5 clk = ~clk;

   // rx_tick once every 4 clocks, changed on the falling edge
   initial begin
      int k = 0;
      forever begin
         @(negedge clk);
         rx_tick = (k == 0);
         k = (k + 1) % 4;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_wait(input int n);
      int c = 0;
      while (c < n) begin
         @(posedge clk);
         if (rx_tick) c++;
      end
      #1;
   endtask

   task automatic do_read();
      rd = 1'b1;
      step();
      rd = 1'b0;
      unread = 1'b0;
   endtask

   // One frame: 8 ticks per bit; stop is sampled on its 5th tick after the line changes
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok,
                             input logic rd_coinc);
      exp_t e;
      logic par;
      rxd = 1'b0;
      tick_wait(8);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick_wait(8);
      end
      par = (^b) ^ ~par_ok;
`ifdef UART_RX_PARITY_EN
      rxd = par;
      tick_wait(8);
      e.pe = (^b) ^ par;
`else
      e.pe = 1'b0;
`endif
      e.d  = b;
      e.fe = ~stop;
      e.ov = unread && !rd_coinc;
      unread = 1'b1;
      sb.push_back(e);
      rxd = stop;
      tick_wait(4);
      if (rd_coinc) begin
         repeat (3) step();
         rd = 1'b1;
         step();
         rd = 1'b0;
      end else begin
         tick_wait(1);
      end
      tick_wait(3);
   endtask

   // Monitor: a completion is visible as data_ready rising, data_ready held across a read,
   // or any error pulse; otherwise data must not change
   initial begin
      logic       pdr = 1'b0;
      logic       prd = 1'b0;
      logic [7:0] pdata = 8'h00;
      logic       trig;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pdr = 1'b0;
            prd = 1'b0;
            pdata = 8'h00;
         end else begin
            trig = (!pdr && data_ready) || (pdr && data_ready && prd) ||
                   overrun || frame_err || parity_err;
            if (trig) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_completion actual data=%0h required none", data);
               end else begin
                  e = sb.pop_front();
                  chk("data", {24'd0, data}, {24'd0, e.d});
                  chk("data_ready", {31'd0, data_ready}, 32'd1);
                  chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
                  chk("overrun", {31'd0, overrun}, {31'd0, e.ov});
                  chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
               end
            end else begin
               chk("data_hold", {24'd0, data}, {24'd0, pdata});
            end
            pdr = data_ready;
            prd = rd;
            pdata = data;
         end
      end
   end

   initial begin
      logic [7:0] f0 = 8'hF0;
      logic [7:0] b;
      logic       coinc;
      logic       pok;

      repeat (3) step();
      chk("rst_data", {24'd0, data}, 32'h0);
      chk("rst_data_ready", {31'd0, data_ready}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
      rst_n = 1'b1;
      tick_wait(4);

      send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
      tick_wait(2);
      do_read();
      chk("read_clears_ready", {31'd0, data_ready}, 32'd0);

      rxd = 1'b0;
      tick_wait(2);
      chk("glitch_busy", {31'd0, busy}, 32'd1);
      rxd = 1'b1;
      tick_wait(4);
      chk("glitch_idle", {31'd0, busy}, 32'd0);
      chk("glitch_no_ready", {31'd0, data_ready}, 32'd0);

      send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      tick_wait(20);
      chk("break_hold", {31'd0, busy}, 32'd1);
      do_read();
      rxd = 1'b1;
      tick_wait(2);
      chk("break_exit", {31'd0, busy}, 32'd0);
      send_frame(8'h55, 1'b1, 1'b1, 1'b0);
      do_read();

      send_frame(8'h01, 1'b1, 1'b1, 1'b0);
      send_frame(8'hFE, 1'b1, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
      chk("coinc_ready_kept", {31'd0, data_ready}, 32'd1);
      do_read();

      rxd = 1'b0;
      tick_wait(8);
      for (int i = 0; i < 4; i++) begin
         rxd = f0[i];
         tick_wait(8);
      end
      chk("midframe_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_data", {24'd0, data}, 32'h0);
      chk("midrst_ready", {31'd0, data_ready}, 32'd0);
      unread = 1'b0;
      rxd = 1'b1;
      repeat (3) step();
      rst_n = 1'b1;
      tick_wait(4);
      send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
      do_read();

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      do_read();
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      do_read();
`endif

      for (int n = 0; n < 12; n++) begin
         b = 8'($urandom);
         coinc = 1'($urandom_range(0, 1));
         pok = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) do_read();
         tick_wait($urandom_range(0, 5));
         send_frame(b, 1'b1, pok, coinc);
      end

      tick_wait(4);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
